// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush event counters for performance debug.
module id_ex_stage #(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ALU_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic [ALU_W-1:0]  id_alu_op,
    input  logic              flush,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [ALU_W-1:0]  ex_alu_op,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic hazard;
    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (ex_rd == id_rs);
        rt_match = id_uses_rt & (ex_rd == id_rt);
        // A load targeting r0 never produces a value worth waiting for.
        hazard   = ~rst & ex_valid & ex_mem_read & (|ex_rd) & id_valid & (rs_match | rt_match);
    end

    // A taken branch redirects fetch, so it overrides the stall.
    always_comb begin
        pc_write    = ~hazard | flush;
        if_id_write = ~hazard | flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush || hazard) begin
            ex_valid      <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_op     <= '0;
        end else begin
            ex_valid      <= id_valid;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_alu_op     <= id_alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            if (flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end else if (hazard) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage, built with 4-bit counters so
// saturation is reachable in a few dozen cycles.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [3:0]  id_alu_op;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] ex_rs_data, ex_rt_data, ex_imm;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [3:0]  ex_alu_op;
    logic        pc_write, if_id_write;
    logic [3:0]  stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(
        .REG_W (4),
        .DATA_W(16),
        .ALU_W (4),
        .CNT_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .id_alu_op    (id_alu_op),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_op    (ex_alu_op),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid      = 1'b0;
        id_rs         = '0;
        id_rt         = '0;
        id_rd         = '0;
        id_uses_rt    = 1'b0;
        id_rs_data    = '0;
        id_rt_data    = '0;
        id_imm        = '0;
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_mem_to_reg = 1'b0;
        id_alu_op     = '0;
        flush         = 1'b0;
    endtask

    task automatic load(input logic [3:0] rd);
        idle();
        id_valid      = 1'b1;
        id_rs         = 4'd1;
        id_rd         = rd;
        id_reg_write  = 1'b1;
        id_mem_read   = 1'b1;
        id_mem_to_reg = 1'b1;
    endtask

    task automatic alu(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
        idle();
        id_valid     = 1'b1;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_uses_rt   = 1'b1;
        id_reg_write = 1'b1;
        id_alu_op    = 4'h2;
    endtask

    task automatic store(input logic [3:0] rt, input logic uses_rt);
        idle();
        id_valid     = 1'b1;
        id_rs        = 4'd1;
        id_rt        = rt;
        id_uses_rt   = uses_rt;
        id_mem_write = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_ex_mem_read", ex_mem_read, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_pc_write", pc_write, 1);
        check("rst_if_id_write", if_id_write, 1);

        // Load r3 then add rs=3: one bubble, then the add enters EX.
        load(4'd3);
        tick();
        check("lu_ex_mem_read", ex_mem_read, 1);
        alu(4'd3, 4'd4, 4'd6);
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_if_id_write", if_id_write, 0);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_rd", ex_rd, 0);
        check("lu_bubble_reg_write", ex_reg_write, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_pc_write_after", pc_write, 1);
        tick();
        check("lu_ex_rs", ex_rs, 3);
        check("lu_ex_rd", ex_rd, 6);
        check("lu_ex_valid", ex_valid, 1);
        check("lu_stall_once", stall_cnt, 1);

        // Store reading rt=3 stalls; same store not reading rt does not.
        load(4'd3);
        tick();
        store(4'd3, 1'b1);
        #1;
        check("st_rt_pc_write", pc_write, 0);
        tick();
        check("st_rt_bubble", ex_valid, 0);
        check("st_rt_stall_cnt", stall_cnt, 2);
        tick();
        check("st_rt_mem_write", ex_mem_write, 1);
        load(4'd3);
        tick();
        store(4'd3, 1'b0);
        #1;
        check("st_nort_pc_write", pc_write, 1);
        tick();
        check("st_nort_valid", ex_valid, 1);
        check("st_nort_ex_rt", ex_rt, 3);
        check("st_nort_stall_cnt", stall_cnt, 2);

        // Load to r0 never stalls.
        load(4'd0);
        tick();
        alu(4'd0, 4'd0, 4'd7);
        #1;
        check("r0_pc_write", pc_write, 1);
        tick();
        check("r0_ex_rd", ex_rd, 7);
        check("r0_stall_cnt", stall_cnt, 2);

        // Hazard and flush together: flush wins.
        do_reset();
        load(4'd3);
        tick();
        alu(4'd3, 4'd2, 4'd5);
        flush = 1'b1;
        #1;
        check("hf_pc_write", pc_write, 1);
        check("hf_if_id_write", if_id_write, 1);
        tick();
        check("hf_bubble_valid", ex_valid, 0);
        check("hf_bubble_rs", ex_rs, 0);
        check("hf_flush_cnt", flush_cnt, 1);
        check("hf_stall_cnt", stall_cnt, 0);

        // Independent ALU stream.
        alu(4'd1, 4'd2, 4'd5);
        id_rs_data = 16'h1234;
        id_rt_data = 16'hBEEF;
        id_imm     = 16'h0007;
        id_alu_op  = 4'hA;
        #1;
        check("alu_pc_write", pc_write, 1);
        tick();
        check("alu_valid", ex_valid, 1);
        check("alu_rs", ex_rs, 1);
        check("alu_rt", ex_rt, 2);
        check("alu_rd", ex_rd, 5);
        check("alu_rs_data", ex_rs_data, 16'h1234);
        check("alu_rt_data", ex_rt_data, 16'hBEEF);
        check("alu_imm", ex_imm, 16'h0007);
        check("alu_op", ex_alu_op, 4'hA);
        check("alu_reg_write", ex_reg_write, 1);
        alu(4'd7, 4'd8, 4'd9);
        id_rs_data = 16'h00FF;
        id_rt_data = 16'hA5A5;
        id_alu_op  = 4'h3;
        tick();
        check("alu2_rd", ex_rd, 9);
        check("alu2_rt_data", ex_rt_data, 16'hA5A5);
        check("alu2_op", ex_alu_op, 4'h3);
        check("alu2_stall_cnt", stall_cnt, 0);

        // Invalid slot loads fields as given.
        idle();
        id_rs = 4'd4;
        tick();
        check("inv_valid", ex_valid, 0);
        check("inv_rs", ex_rs, 4);

        // 19 stalls on a 4-bit counter saturate at 15.
        for (int i = 0; i < 19; i++) begin
            load(4'd3);
            tick();
            alu(4'd3, 4'd1, 4'd2);
            tick();
            tick();
            if (i == 14) check("sat_at_15", stall_cnt, 4'hF);
        end
        check("sat_hold", stall_cnt, 4'hF);
        check("sat_flush_cnt", flush_cnt, 1);

        // Reset while a hazard is pending returns to reset state.
        load(4'd3);
        tick();
        alu(4'd3, 4'd1, 4'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", ex_valid, 0);
        check("rst_mid_mem_read", ex_mem_read, 0);
        check("rst_mid_stall_cnt", stall_cnt, 0);
        check("rst_mid_flush_cnt", flush_cnt, 0);
        #1;
        check("rst_mid_pc_write", pc_write, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
